// File: rtl/cpu_req_traffic_gen.sv
// Configurable CPU-port request engine: read, write or write-then-verify runs
// over a strided address range, with mismatch, timeout and done reporting.
//
// state  | meaning
// IDLE   | waiting for start
// ISSUE  | reqValid_CPU high, waiting for respHit_CPU or timeout
// GAP    | idle spacing after a hit, then next request / next pass / finish
// FINISH | one-cycle done pulse
module cpu_req_traffic_gen #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int CNT_WIDTH      = 16,
    parameter int GAP_WIDTH      = 8,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_WIDTH-1:0] DATA_SEED = DATA_WIDTH'(32'hA5A5_0000)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr,
    input  logic [ADDR_WIDTH-1:0] cfg_stride,
    input  logic [CNT_WIDTH-1:0]  cfg_count,
    input  logic [GAP_WIDTH-1:0]  cfg_gap,
    input  logic [1:0]            cfg_mode,
    output logic                  reqValid_CPU,
    output logic [ADDR_WIDTH-1:0] reqAddress_CPU,
    output logic [DATA_WIDTH-1:0] reqDataIn_CPU,
    output logic                  reqWen_CPU,
    input  logic [DATA_WIDTH-1:0] respDataOut_CPU,
    input  logic                  respHit_CPU,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic                  timeout
);
    localparam int WAIT_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_WIDTH-1:0] WAIT_LOAD = WAIT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, GAP, FINISH} state_t;
    state_t state, state_next;

    logic [ADDR_WIDTH-1:0] base_q, stride_q;
    logic [CNT_WIDTH-1:0]  count_q, idx_q, idx_next;
    logic [GAP_WIDTH-1:0]  gap_q, gap_cnt, gap_next;
    logic [WAIT_WIDTH-1:0] wait_cnt, wait_next;
    logic                  verify_run_q, verify_pass_q, verify_next;

    logic                  valid_next, wen_next, busy_next, done_next, timeout_next;
    logic [ADDR_WIDTH-1:0] addr_next, first_next;
    logic [DATA_WIDTH-1:0] data_next;
    logic [CNT_WIDTH-1:0]  err_next;

    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_WIDTH-1:0] a);
        return DATA_WIDTH'(a) ^ DATA_SEED;
    endfunction

    always_comb begin
        state_next   = state;
        addr_next    = reqAddress_CPU;
        data_next    = reqDataIn_CPU;
        wen_next     = reqWen_CPU;
        idx_next     = idx_q;
        wait_next    = wait_cnt;
        gap_next     = gap_cnt;
        verify_next  = verify_pass_q;
        err_next     = err_count;
        first_next   = first_err_addr;
        timeout_next = timeout;
        unique case (state)
            IDLE: begin
                if (start) begin
                    err_next     = '0;
                    first_next   = '0;
                    timeout_next = 1'b0;
                    idx_next     = '0;
                    verify_next  = 1'b0;
                    wait_next    = WAIT_LOAD;
                    addr_next    = cfg_base_addr;
                    wen_next     = (cfg_mode == 2'b01) || (cfg_mode == 2'b10);
                    data_next    = wen_next ? pattern(cfg_base_addr) : '0;
                    state_next   = (cfg_count == '0) ? FINISH : ISSUE;
                end
            end
            ISSUE: begin
                if (respHit_CPU) begin
                    // gap of 0 behaves as 1: the down-counter terminates immediately
                    gap_next   = (gap_q == '0) ? '0 : gap_q - GAP_WIDTH'(1);
                    idx_next   = idx_q + CNT_WIDTH'(1);
                    state_next = GAP;
                    if (verify_pass_q && (respDataOut_CPU != pattern(reqAddress_CPU))) begin
                        if (err_count == '0) first_next = reqAddress_CPU;
                        if (err_count != '1) err_next = err_count + CNT_WIDTH'(1);
                    end
                end else if (wait_cnt == '0) begin
                    timeout_next = 1'b1;
                    state_next   = FINISH;
                end else begin
                    wait_next = wait_cnt - WAIT_WIDTH'(1);
                end
            end
            GAP: begin
                if (gap_cnt != '0) begin
                    gap_next = gap_cnt - GAP_WIDTH'(1);
                end else if (idx_q != count_q) begin
                    addr_next  = reqAddress_CPU + stride_q;
                    data_next  = reqWen_CPU ? pattern(addr_next) : '0;
                    wait_next  = WAIT_LOAD;
                    state_next = ISSUE;
                end else if (verify_run_q && !verify_pass_q) begin
                    verify_next = 1'b1;
                    idx_next    = '0;
                    addr_next   = base_q;
                    wen_next    = 1'b0;
                    data_next   = '0;
                    wait_next   = WAIT_LOAD;
                    state_next  = ISSUE;
                end else begin
                    state_next = FINISH;
                end
            end
            FINISH:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
        valid_next = (state_next == ISSUE);
        busy_next  = (state_next == ISSUE) || (state_next == GAP);
        done_next  = (state_next == FINISH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            reqValid_CPU   <= 1'b0;
            reqAddress_CPU <= '0;
            reqDataIn_CPU  <= '0;
            reqWen_CPU     <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            timeout        <= 1'b0;
            idx_q          <= '0;
            wait_cnt       <= '0;
            gap_cnt        <= '0;
            verify_pass_q  <= 1'b0;
            verify_run_q   <= 1'b0;
            base_q         <= '0;
            stride_q       <= '0;
            count_q        <= '0;
            gap_q          <= '0;
        end else begin
            state          <= state_next;
            reqValid_CPU   <= valid_next;
            reqAddress_CPU <= addr_next;
            reqDataIn_CPU  <= data_next;
            reqWen_CPU     <= wen_next;
            busy           <= busy_next;
            done           <= done_next;
            err_count      <= err_next;
            first_err_addr <= first_next;
            timeout        <= timeout_next;
            idx_q          <= idx_next;
            wait_cnt       <= wait_next;
            gap_cnt        <= gap_next;
            verify_pass_q  <= verify_next;
            if (state == IDLE && start) begin
                base_q       <= cfg_base_addr;
                stride_q     <= cfg_stride;
                count_q      <= cfg_count;
                gap_q        <= cfg_gap;
                verify_run_q <= (cfg_mode == 2'b10);
            end
        end
    end
endmodule

// File: tb/tb_cpu_req_traffic_gen.sv
// Scoreboard bench for cpu_req_traffic_gen: a memory responder pops expected
// requests on each hit; protocol timing is monitored on the falling edge.
module tb_cpu_req_traffic_gen;
    localparam logic [31:0] SEED = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [31:0] cfg_base_addr, cfg_stride;
    logic [15:0] cfg_count;
    logic [7:0]  cfg_gap;
    logic [1:0]  cfg_mode;
    logic        reqValid_CPU, reqWen_CPU, respHit_CPU;
    logic [31:0] reqAddress_CPU, reqDataIn_CPU, respDataOut_CPU;
    logic        busy, done, timeout;
    logic [15:0] err_count;
    logic [31:0] first_err_addr;

    cpu_req_traffic_gen #(.TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_base_addr(cfg_base_addr), .cfg_stride(cfg_stride), .cfg_count(cfg_count),
        .cfg_gap(cfg_gap), .cfg_mode(cfg_mode),
        .reqValid_CPU(reqValid_CPU), .reqAddress_CPU(reqAddress_CPU),
        .reqDataIn_CPU(reqDataIn_CPU), .reqWen_CPU(reqWen_CPU),
        .respDataOut_CPU(respDataOut_CPU), .respHit_CPU(respHit_CPU),
        .busy(busy), .done(done), .err_count(err_count),
        .first_err_addr(first_err_addr), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic [31:0] data;
    } req_t;

    req_t        sb[$];
    logic [31:0] mem [logic [31:0]];
    int          n_chk = 0, n_pass = 0;
    int          lat = 2;
    bit          resp_en = 1'b1, corrupt_en = 1'b0;
    logic [31:0] corrupt_addr = 32'h0;
    int          exp_gap = 1, done_cnt = 0, hits = 0, valid_hi = 0, low_cnt = 0, wait_ctr = 0;
    logic        prev_valid = 1'b0, prev_hit = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    endtask

    // memory responder plus protocol monitor
    always @(negedge clk) begin
        bit          hit_now;
        logic [31:0] rd;
        req_t        e;
        hit_now = 1'b0;
        rd      = 32'h0;
        if (rst) begin
            prev_valid = 1'b0;
            prev_hit   = 1'b0;
            low_cnt    = 0;
            wait_ctr   = 0;
        end else begin
            if (done) done_cnt++;
            if (reqValid_CPU) valid_hi++;
            if (prev_hit) chk("valid_drop_after_hit", reqValid_CPU, 1'b0);
            else if (prev_valid && reqValid_CPU) chk("addr_hold", reqAddress_CPU, prev_addr);
            if (reqValid_CPU && !prev_valid) begin
                if (low_cnt != 0) chk("gap_len", low_cnt, exp_gap);
                low_cnt = 0;
            end else if (busy && !reqValid_CPU) low_cnt++;
            else if (!busy) low_cnt = 0;

            if (reqValid_CPU && resp_en) begin
                if (wait_ctr == lat) begin
                    hit_now  = 1'b1;
                    wait_ctr = 0;
                end else wait_ctr++;
            end else wait_ctr = 0;

            if (hit_now) begin
                hits++;
                if (sb.size() == 0) chk("sb_underflow", 1'b1, 1'b0);
                else begin
                    e = sb.pop_front();
                    chk("req_addr", reqAddress_CPU, e.addr);
                    chk("req_wen", reqWen_CPU, e.wen);
                    if (e.wen) chk("req_wdata", reqDataIn_CPU, e.data);
                end
                if (reqWen_CPU) mem[reqAddress_CPU] = reqDataIn_CPU;
                else begin
                    rd = mem.exists(reqAddress_CPU) ? mem[reqAddress_CPU] : 32'h0;
                    if (corrupt_en && reqAddress_CPU == corrupt_addr) rd = rd ^ 32'h1;
                end
            end
            prev_valid = reqValid_CPU;
            prev_hit   = hit_now;
            prev_addr  = reqAddress_CPU;
        end
        respHit_CPU     = hit_now;
        respDataOut_CPU = rd;
    end

    task automatic run(input logic [31:0] base, input logic [31:0] stride, input logic [15:0] cnt,
                       input logic [7:0] gap, input logic [1:0] mode, input bit push,
                       input bit poke, output int lat_out);
        int passes;
        passes = (mode == 2'b10) ? 2 : 1;
        if (push) begin
            for (int p = 0; p < passes; p++) begin
                for (int i = 0; i < int'(cnt); i++) begin
                    req_t r;
                    r.addr = base + stride * 32'(i);
                    r.wen  = (mode == 2'b01) || (mode == 2'b10 && p == 0);
                    r.data = r.addr ^ SEED;
                    sb.push_back(r);
                end
            end
        end
        exp_gap  = (gap == 8'd0) ? 1 : int'(gap);
        done_cnt = 0;
        hits     = 0;
        valid_hi = 0;
        @(posedge clk); #1;
        start = 1'b1; cfg_base_addr = base; cfg_stride = stride;
        cfg_count = cnt; cfg_gap = gap; cfg_mode = mode;
        @(posedge clk); #1;
        start = 1'b0;
        // later config changes must not disturb the run
        cfg_base_addr = 32'hDEAD_BEE0; cfg_stride = 32'h40; cfg_count = 16'd9;
        cfg_gap = 8'd7; cfg_mode = 2'b01;
        if (poke) begin
            repeat (3) @(posedge clk);
            #1 start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
        end
        lat_out = -1;
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk); #1;
            if (done_cnt != 0) begin
                lat_out = n;
                break;
            end
        end
        chk("done_seen", done_cnt != 0, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        chk("done_once", done_cnt, 1);
        chk("busy_after_done", busy, 1'b0);
        chk("sb_drained", sb.size(), 0);
        sb.delete();
    endtask

    initial begin
        int l;
        rst = 1'b1; start = 1'b0;
        cfg_base_addr = '0; cfg_stride = '0; cfg_count = '0; cfg_gap = '0; cfg_mode = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", reqValid_CPU, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_addr", reqAddress_CPU, 32'h0);
        chk("rst_err", err_count, 16'h0);
        chk("rst_timeout", timeout, 1'b0);
        rst = 1'b0;

        // plain read run
        run(32'h0, 32'h4, 16'd5, 8'd1, 2'b00, 1'b1, 1'b0, l);
        chk("read_hits", hits, 5);
        chk("read_err", err_count, 16'h0);

        // write-then-verify, correct memory
        lat = 1;
        run(32'h100, 32'h4, 16'd4, 8'd2, 2'b10, 1'b1, 1'b0, l);
        chk("verify_hits", hits, 8);
        chk("verify_err", err_count, 16'h0);

        // write-then-verify, one corrupted read
        corrupt_en = 1'b1; corrupt_addr = 32'h108;
        run(32'h100, 32'h4, 16'd4, 8'd1, 2'b10, 1'b1, 1'b0, l);
        corrupt_en = 1'b0;
        chk("corrupt_hits", hits, 8);
        chk("corrupt_err", err_count, 16'h1);
        chk("corrupt_first_addr", first_err_addr, 32'h108);

        // timeout with no responses
        resp_en = 1'b0;
        run(32'h200, 32'h4, 16'd3, 8'd1, 2'b00, 1'b0, 1'b0, l);
        resp_en = 1'b1;
        chk("timeout_valid_cycles", valid_hi, 16);
        chk("timeout_flag", timeout, 1'b1);
        chk("timeout_hits", hits, 0);

        // address wrap in write mode; also clears timeout on start
        lat = 0;
        run(32'hFFFF_FFF8, 32'h8, 16'd2, 8'd3, 2'b01, 1'b1, 1'b0, l);
        chk("wrap_hits", hits, 2);
        chk("wrap_timeout_cleared", timeout, 1'b0);

        // count zero: done one cycle after start, no request
        run(32'h300, 32'h4, 16'd0, 8'd1, 2'b00, 1'b0, 1'b0, l);
        chk("cnt0_latency", l, 0);
        chk("cnt0_no_valid", valid_hi, 0);

        // reset mid-request
        resp_en = 1'b0;
        @(posedge clk); #1;
        start = 1'b1; cfg_base_addr = 32'h500; cfg_stride = 32'h4;
        cfg_count = 16'd3; cfg_gap = 8'd0; cfg_mode = 2'b00;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("pre_rst_valid", reqValid_CPU, 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rst_mid_valid", reqValid_CPU, 1'b0);
        chk("rst_mid_busy", busy, 1'b0);
        rst = 1'b0;
        resp_en = 1'b1;
        lat = 2;

        // fresh run after reset, reserved mode reads, gap 0, start poked while busy
        run(32'h40, 32'h10, 16'd3, 8'd0, 2'b11, 1'b1, 1'b1, l);
        chk("post_rst_hits", hits, 3);
        chk("post_rst_err", err_count, 16'h0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule
